// File: rtl/uart_pkg.sv
// Shared definitions for the UART word receiver: bit-FSM encoding and
// framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int unsigned DEFAULT_BPS_DIV = 216;
  localparam int unsigned FRAME_BITS      = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 receiver: 2-flop synchronizer, start-bit glitch filter,
// mid-bit sampling of data and stop bits.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BPS_DIV = DEFAULT_BPS_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_TICK = 16'(BPS_DIV / 2 - 1);
  localparam logic [15:0] FULL_TICK = 16'(BPS_DIV - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(FRAME_BITS - 1);

  rx_state_e   state_q, state_d;
  logic [15:0] timer_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic        tick;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tick    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rxd_prev && !rxd_sync) state_d = ST_START;
      end
      ST_START: begin
        tick = (timer_q == HALF_TICK);
        if (tick) state_d = rxd_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        tick = (timer_q == FULL_TICK);
        if (tick && bit_idx_q == LAST_BIT) state_d = ST_STOP;
      end
      ST_STOP: begin
        tick = (timer_q == FULL_TICK);
        // Leaving at mid-stop lets a back-to-back start edge be seen.
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      timer_q    <= (state_q == ST_IDLE || tick) ? '0 : timer_q + 16'd1;
      if (state_q == ST_IDLE) bit_idx_q <= '0;
      if (state_q == ST_DATA && tick) begin
        shift_q   <= {rxd_sync, shift_q[7:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (state_q == ST_STOP && tick) begin
        if (rxd_sync) begin
          byte_valid <= 1'b1;
          byte_out   <= shift_q;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// UART receiver that packs four bytes MSB-first into a 32-bit FIFO word.
// Define UART_RX_TIMEOUT_EN to discard partial words after a long idle line.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int unsigned BPS_DIV      = DEFAULT_BPS_DIV,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        full,
  output logic        wr_en,
  output logic [31:0] data_out,
  output logic        byte_valid,
  output logic [7:0]  byte_out,
  output logic        frame_err,
  output logic        overflow,
  output logic        rx_busy
);

  logic [1:0]  byte_cnt;
  logic [31:0] word_buf;
  logic        timeout_hit;

  uart_rx_byte #(.BPS_DIV(BPS_DIV)) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .frame_err  (frame_err),
    .busy       (rx_busy)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * BPS_DIV - 1);
  logic [31:0] idle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (rx_busy || byte_valid || byte_cnt == 2'd0) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout_hit = (idle_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      word_buf <= '0;
      data_out <= '0;
      wr_en    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      overflow <= 1'b0;
      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        unique case (byte_cnt)
          2'd0: word_buf[31:24] <= byte_out;
          2'd1: word_buf[23:16] <= byte_out;
          2'd2: word_buf[15:8]  <= byte_out;
          2'd3: begin
            // Fourth byte completes the word: commit or drop it now.
            if (full) begin
              overflow <= 1'b1;
            end else begin
              wr_en    <= 1'b1;
              data_out <= {word_buf[31:8], byte_out};
            end
          end
          default: ;
        endcase
      end else if (timeout_hit) begin
        byte_cnt <= '0;
      end
    end
  end

endmodule
